key_bounce_gen: RTL
===================

# key_bounce_gen

Synthesizable mechanical-key emulator and the transmit-side counterpart of the key debouncer. On command, it drives a key line from its current level to a target level. The line chatters through a pseudo-random number of bounce edges with LFSR-randomised spacing, then settles. It sits in the on-board self-test path, feeding the debouncer's key input so debounce behaviour can be checked in hardware without a physical button.

## Interface
- IDLE_LEVEL, 1'b1: key level out of reset (keys are active-low).
- GAP_W, 12: width of the bounce-gap field; each gap is 1..2^GAP_W cycles.
- HOLD_CYCLES, 1000: stable cycles after the final edge before `done`. Must be ≥1.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.
- sys_clk  in  1  single system clock; all logic rises on it.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_level  in  1  target settled key level.
- cmd_bounces  in  4  bounce pairs N (0..15) preceding the final settle.
- key_out  out  1  emulated key line, registered.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when the command completes.

## Operation
- States: IDLE, BOUNCE, HOLD.
- IDLE:
  - cmd_ready=1 and key_out is stable.
  - On accept with cmd_level == key_out: no edges occur; go directly to done (see Timing); stay in IDLE.
  - On accept with cmd_level ≠ key_out: toggle key_out, set edges_left = 2·N, load the gap counter, go to BOUNCE.
- BOUNCE:
  - The gap counter decrements each cycle.
  - At expiry, toggle key_out and decrement edges_left.
  - If edges_left was already 0 at expiry, do not toggle; load the hold counter and go to HOLD.
  - Total edges per command = 2N+1, so key_out always ends at cmd_level.
- HOLD: count HOLD_CYCLES with key_out constant, then pulse done and return to IDLE.
- Gap draw: G = lfsr[GAP_W-1:0] + 1, sampled on every cycle that toggles key_out. Arithmetic is unsigned, GAP_W+1 bits, with no wrap.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (tap mask 16'hB400).
  - Advances every cycle outside reset, independent of state.
  - Never reaches zero; the same seed gives an identical edge sequence.
- cmd_valid while busy is ignored and not queued. cmd_level and cmd_bounces are captured at accept; later changes have no effect.
- Reset at any time, including mid-BOUNCE or HOLD:
  - key_out=IDLE_LEVEL, state=IDLE, busy=0, done=0.
  - Counters are cleared and lfsr=LFSR_SEED.
  - No done pulse is issued for the aborted command.

## Timing
- Reset values: key_out=IDLE_LEVEL, cmd_ready=1 (combinational from state), busy=0, done=0.
- First edge: key_out changes at the accept edge T (visible the cycle after T). busy rises at the same edge.
- Edge spacing: consecutive edges are exactly G cycles apart, 1 ≤ G ≤ 2^GAP_W.
- Final settle: after the last edge at Tf, a further G-cycle gap elapses (final-gap expiry), then done=1 in the cycle starting at Tf + G + HOLD_CYCLES.
- Back-to-back: busy=0 and cmd_ready=1 in the same cycle as done, so a back-to-back command can be accepted on the done cycle.
- Same-level command: done=1 in the cycle after accept; busy stays 0 and no edge occurs.
- Worst-case command length: (2N+1)·2^GAP_W + HOLD_CYCLES cycles.

## Structure
- Package `key_bounce_pkg` holds:
  - the state enum (IDLE/BOUNCE/HOLD);
  - LFSR_TAPS = 16'hB400;
  - the default LFSR_SEED.
- Sub-module `lfsr16`: clk, async-high rst, seed parameter, 16-bit state out, free-running.
- Top level holds the FSM, the gap counter (GAP_W+1 bits), the 5-bit edges counter, and the hold counter ($clog2(HOLD_CYCLES+1) bits).

## Test plan
- Use GAP_W=4, HOLD_CYCLES=8 for all scenarios.
- Reset release: key_out=1, cmd_ready=1, busy=0, done=0; hold rst 20 cycles and all stay fixed.
- cmd_level=0, cmd_bounces=0: exactly 1 falling edge at accept. done fires 1 cycle at Tf+G+8, with G the gap drawn at the edge. key_out=0 afterwards.
- cmd_level=0, cmd_bounces=3: 7 edges, each gap in 1..16 and matching a reference LFSR model; final key_out=0. Follow with cmd_level=1, cmd_bounces=3: 7 edges, final 1.
- cmd_level=1 while key_out=1: no edges, busy stays 0, done=1 the cycle after accept.
- cmd_valid held during BOUNCE with a different cmd_level: cmd_ready=0, the command is ignored, and the original target is reached.
- rst pulsed mid-BOUNCE: key_out=1 immediately (asynchronous), no done, lfsr=16'hACE1. A rerun of the same command reproduces an identical edge timeline.

Source files
------------

// File: rtl/key_bounce_pkg.sv
// Shared types and constants for the key bounce emulator.
package key_bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One right-shift Galois step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR supplying bounce-gap randomness.
module lfsr16
  import key_bounce_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: drives key_out to a target level through a
// randomised burst of bounce edges, then holds it stable before signalling done.
module key_bounce_gen
  import key_bounce_pkg::*;
#(
  parameter logic        IDLE_LEVEL  = 1'b1,
  parameter int unsigned GAP_W       = 12,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_level,
  input  logic [3:0] cmd_bounces,
  output logic       key_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = GAP_W + 1;
  localparam int unsigned EDGE_W = 5;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t              state_q, state_d;
  logic                key_q, key_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [EDGE_W-1:0]   edges_q, edges_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [15:0]         lfsr;
  logic [CNT_W-1:0]    gap_draw;
  logic                lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (sys_clk),
    .rst   (rst),
    .state (lfsr)
  );

  // Gap in 1..2^GAP_W, widened so the +1 never wraps.
  assign gap_draw    = CNT_W'(lfsr[GAP_W-1:0]) + CNT_W'(1);
  assign lfsr_unused = ^lfsr;

  assign cmd_ready = (state_q == IDLE);
  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      edges_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      edges_q <= edges_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    gap_d   = gap_q;
    edges_d = edges_q;
    hold_d  = hold_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_level == key_q) begin
            done_d = 1'b1;
          end else begin
            key_d   = ~key_q;
            edges_d = {cmd_bounces, 1'b0};
            gap_d   = gap_draw;
            state_d = BOUNCE;
          end
        end
      end

      BOUNCE: begin
        // Expiry when the counter reaches 1, so edges are exactly G cycles apart.
        if (gap_q == CNT_W'(1)) begin
          if (edges_q == '0) begin
            gap_d   = '0;
            hold_d  = HOLD_W'(HOLD_CYCLES);
            state_d = HOLD;
          end else begin
            key_d   = ~key_q;
            edges_d = edges_q - EDGE_W'(1);
            gap_d   = gap_draw;
          end
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end

      HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          hold_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
